// File: rtl/am_demod_pkg.sv
// Shared types and helpers for the AM envelope demodulator.
package am_demod_pkg;

    // Output-side handshake state: accumulating a window, or holding a result.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Default geometry; modules carry their own parameters derived the same way.
    localparam int W_DEF      = 16;
    localparam int LOGDEC_DEF = 5;
    localparam int ACC_W      = W_DEF + LOGDEC_DEF;
    localparam int DEC        = 1 << LOGDEC_DEF;

    // abs_u works on a wide sign-extended value so any sample width up to
    // ABS_MAXW can use it; the most negative W-bit value becomes 2**(W-1),
    // which still fits in W unsigned bits after truncation.
    localparam int ABS_MAXW = 64;

    function automatic logic [ABS_MAXW-1:0] abs_u(input logic signed [ABS_MAXW-1:0] x);
        logic [ABS_MAXW-1:0] r;
        r = x[ABS_MAXW-1] ? unsigned'(-x) : unsigned'(x);
        return r;
    endfunction

endpackage

// File: rtl/am_env_accum.sv
// Rectify, accumulate and count samples; strobe when a window completes.
module am_env_accum
    import am_demod_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOGDEC = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                smp_fire,
    input  logic [W-1:0]        smp_data,
    output logic                dump,
    output logic [W+LOGDEC-1:0] dump_sum
);

    localparam int AW = W + LOGDEC;

    logic [AW-1:0]       acc_q, acc_d;
    logic [LOGDEC-1:0]   cnt_q, cnt_d;
    logic signed [ABS_MAXW-1:0] smp_ext;
    logic [ABS_MAXW-1:0] mag_wide;
    logic [W-1:0]        mag;
    logic [AW-1:0]       sum_inc;
    logic                unused_mag_hi;

    assign smp_ext       = {{(ABS_MAXW-W){smp_data[W-1]}}, smp_data};
    assign mag_wide      = abs_u(smp_ext);
    assign mag           = mag_wide[W-1:0];
    assign unused_mag_hi = ^mag_wide[ABS_MAXW-1:W];

    // Sum including the sample being accepted this cycle.
    assign sum_inc  = acc_q + AW'(mag);
    assign dump_sum = sum_inc;

    // Window bookkeeping: add on accept, clear after the last sample.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dump  = 1'b0;
        if (smp_fire) begin
            if (&cnt_q) begin
                dump  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_inc;
                cnt_d = cnt_q + LOGDEC'(1);
            end
        end
    end

    // Accumulator and sample-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: boxcar envelope with valid/ready output and
// per-frame max/min tracking for modulation-depth estimation.
module am_demod
    import am_demod_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOGDEC = 5,
    parameter int FRAME  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         env_valid,
    input  logic         env_ready,
    output logic [W-1:0] env_data,
    output logic         depth_valid,
    output logic [W-1:0] depth_max,
    output logic [W-1:0] depth_min
);

    localparam int AW = W + LOGDEC;
    localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   env_data_q, env_data_d;
    logic [W-1:0]   run_max_q, run_max_d;
    logic [W-1:0]   run_min_q, run_min_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic           depth_valid_q, depth_valid_d;
    logic [W-1:0]   depth_max_q, depth_max_d;
    logic [W-1:0]   depth_min_q, depth_min_d;

    logic           smp_fire;
    logic           env_fire;
    logic           dump;
    logic [AW-1:0]  dump_sum;
    logic [W-1:0]   new_max, new_min;

    // HOLD passes env_ready straight through so a new window can start in
    // the same cycle the previous envelope is taken.
    assign in_ready    = (state_q == ACC) || env_ready;
    assign smp_fire    = in_valid && in_ready;
    assign env_valid   = (state_q == HOLD);
    assign env_fire    = env_valid && env_ready;
    assign env_data    = env_data_q;
    assign depth_valid = depth_valid_q;
    assign depth_max   = depth_max_q;
    assign depth_min   = depth_min_q;

    am_env_accum #(
        .W      (W),
        .LOGDEC (LOGDEC)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .smp_fire (smp_fire),
        .smp_data (in_data),
        .dump     (dump),
        .dump_sum (dump_sum)
    );

    // Output FSM and envelope register; a dump always (re)enters HOLD.
    always_comb begin
        state_d    = state_q;
        env_data_d = env_data_q;
        if (dump) begin
            env_data_d = dump_sum[AW-1:LOGDEC];
        end
        case (state_q)
            ACC: begin
                if (dump) state_d = HOLD;
            end
            HOLD: begin
                if (env_fire) state_d = dump ? HOLD : ACC;
            end
            default: state_d = ACC;
        endcase
    end

    assign new_max = (env_data_q > run_max_q) ? env_data_q : run_max_q;
    assign new_min = (env_data_q < run_min_q) ? env_data_q : run_min_q;

    // Frame statistics: fold each transferred envelope into max/min and
    // publish the result on the last transfer of the frame.
    always_comb begin
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        frame_d       = frame_q;
        depth_valid_d = 1'b0;
        depth_max_d   = depth_max_q;
        depth_min_d   = depth_min_q;
        if (env_fire) begin
            if (frame_q == FW'(FRAME - 1)) begin
                depth_valid_d = 1'b1;
                depth_max_d   = new_max;
                depth_min_d   = new_min;
                run_max_d     = '0;
                run_min_d     = '1;
                frame_d       = '0;
            end else begin
                run_max_d = new_max;
                run_min_d = new_min;
                frame_d   = frame_q + FW'(1);
            end
        end
    end

    // State, envelope and depth registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACC;
            env_data_q    <= '0;
            run_max_q     <= '0;
            run_min_q     <= '1;
            frame_q       <= '0;
            depth_valid_q <= 1'b0;
            depth_max_q   <= '0;
            depth_min_q   <= '0;
        end else begin
            state_q       <= state_d;
            env_data_q    <= env_data_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            frame_q       <= frame_d;
            depth_valid_q <= depth_valid_d;
            depth_max_q   <= depth_max_d;
            depth_min_q   <= depth_min_d;
        end
    end

endmodule

// File: tb/tb_am_demod.sv
// Directed self-checking bench for am_demod (W=16, DEC=32, FRAME=64).
module tb_am_demod;

    localparam int W      = 16;
    localparam int LOGDEC = 5;
    localparam int FRAME  = 64;
    localparam int DEC    = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         env_valid;
    logic         env_ready;
    logic [W-1:0] env_data;
    logic         depth_valid;
    logic [W-1:0] depth_max;
    logic [W-1:0] depth_min;

    int checks   = 0;
    int failures = 0;
    int env_q[$];
    int dcount   = 0;
    int dmax     = -1;
    int dmin     = -1;

    am_demod #(.W(W), .LOGDEC(LOGDEC), .FRAME(FRAME)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .env_valid   (env_valid),
        .env_ready   (env_ready),
        .env_data    (env_data),
        .depth_valid (depth_valid),
        .depth_max   (depth_max),
        .depth_min   (depth_min)
    );

    always #5 clk = ~clk;

    // Record every envelope transfer and every depth pulse.
    always @(negedge clk) begin
        if (env_valid && env_ready) env_q.push_back(int'(env_data));
        if (depth_valid) begin
            dcount = dcount + 1;
            dmax   = int'(depth_max);
            dmin   = int'(depth_min);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        env_q.delete();
        dcount = 0;
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic push(input logic [W-1:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_timeout data=%0d never accepted within 100 cycles", d);
        end
    endtask

    task automatic push_window(input int amp);
        repeat (DEC) push(16'(amp));
    endtask

    function automatic int q_at(input int idx);
        return (env_q.size() > idx) ? env_q[idx] : -1;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd1234;
        env_ready = 1'b1;
        tick();
        tick();
        checks++; if (env_valid !== 1'b0) begin failures++; $display("FAIL reset_env_valid got=%b exp=0", env_valid); end
        checks++; if (env_data !== 16'd0) begin failures++; $display("FAIL reset_env_data got=%0d exp=0", env_data); end
        checks++; if (depth_valid !== 1'b0) begin failures++; $display("FAIL reset_depth_valid got=%b exp=0", depth_valid); end
        checks++; if (depth_max !== 16'd0) begin failures++; $display("FAIL reset_depth_max got=%0d exp=0", depth_max); end
        checks++; if (depth_min !== 16'd0) begin failures++; $display("FAIL reset_depth_min got=%0d exp=0", depth_min); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_const();
        do_reset();
        env_ready = 1'b1;
        repeat (DEC - 1) push(16'd1000);
        checks++; if (env_valid !== 1'b0) begin failures++; $display("FAIL const_early_valid got=%b exp=0", env_valid); end
        push(16'd1000);
        checks++; if ({env_valid, env_data} !== {1'b1, 16'd1000}) begin
            failures++; $display("FAIL const_latency got valid=%b data=%0d exp valid=1 data=1000", env_valid, env_data); end
        push_window(1000);
        tick();
        tick();
        checks++; if (env_q.size() !== 2) begin failures++; $display("FAIL const_count got=%0d exp=2", env_q.size()); end
        checks++; if (q_at(0) !== 1000 || q_at(1) !== 1000) begin
            failures++; $display("FAIL const_values got=%0d,%0d exp=1000,1000", q_at(0), q_at(1)); end
    endtask

    task automatic test_neg_fullscale();
        do_reset();
        env_ready = 1'b1;
        push_window(-32768);
        tick();
        tick();
        checks++; if (q_at(0) !== 32768) begin failures++; $display("FAIL neg_fullscale got=%0d exp=32768", q_at(0)); end
    endtask

    task automatic test_alt();
        do_reset();
        env_ready = 1'b1;
        repeat (DEC / 2) begin push(16'd700); push(16'(-700)); end
        tick();
        tick();
        checks++; if (q_at(0) !== 700) begin failures++; $display("FAIL alt_700 got=%0d exp=700", q_at(0)); end
        repeat (DEC / 2) begin push(16'd0); push(16'd1); end
        tick();
        tick();
        checks++; if (env_q.size() !== 2 || q_at(1) !== 0) begin
            failures++; $display("FAIL trunc_zero got size=%0d val=%0d exp size=2 val=0", env_q.size(), q_at(1)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        env_ready = 1'b0;
        push_window(300);
        checks++; if ({env_valid, env_data} !== {1'b1, 16'd300}) begin
            failures++; $display("FAIL bp_first got valid=%b data=%0d exp valid=1 data=300", env_valid, env_data); end
        in_valid = 1'b1;
        in_data  = 16'd999;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, env_valid, env_data} !== {1'b0, 1'b1, 16'd300}) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got ready=%b valid=%b data=%0d exp ready=0 valid=1 data=300",
                         i, in_ready, env_valid, env_data);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        env_ready = 1'b1;
        // Only the first sample is nonzero, so a lost or repeated sample
        // shows up as a missing envelope or a doubled value.
        push(16'd3200);
        repeat (DEC - 1) push(16'd0);
        tick();
        tick();
        checks++; if (env_q.size() !== 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", env_q.size()); end
        checks++; if (q_at(0) !== 300 || q_at(1) !== 100) begin
            failures++; $display("FAIL bp_values got=%0d,%0d exp=300,100", q_at(0), q_at(1)); end
    endtask

    task automatic test_depth();
        do_reset();
        env_ready = 1'b1;
        for (int k = 0; k < FRAME - 1; k++) push_window(k < 32 ? 1500 : 500);
        checks++; if (dcount !== 0) begin failures++; $display("FAIL depth_early got=%0d exp=0", dcount); end
        push_window(500);
        repeat (3) tick();
        checks++; if (dcount !== 1) begin failures++; $display("FAIL depth_pulses got=%0d exp=1", dcount); end
        checks++; if (dmax !== 1500 || dmin !== 500) begin
            failures++; $display("FAIL depth_frame1 got max=%0d min=%0d exp max=1500 min=500", dmax, dmin); end
        for (int k = 0; k < 10; k++) push_window(800);
        checks++; if ({depth_max, depth_min} !== {16'd1500, 16'd500}) begin
            failures++; $display("FAIL depth_hold got max=%0d min=%0d exp max=1500 min=500", depth_max, depth_min); end
        for (int k = 10; k < FRAME; k++) push_window(k == FRAME - 1 ? 900 : 800);
        repeat (3) tick();
        checks++; if (dcount !== 2 || dmax !== 900 || dmin !== 800) begin
            failures++; $display("FAIL depth_frame2 got n=%0d max=%0d min=%0d exp n=2 max=900 min=800", dcount, dmax, dmin); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        env_ready = 1'b1;
        repeat (5) push_window(1000);
        repeat (17) push(16'd1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({env_valid, env_data} !== {1'b0, 16'd0}) begin
            failures++; $display("FAIL rst_mid_state got valid=%b data=%0d exp valid=0 data=0", env_valid, env_data); end
        env_q.delete();
        dcount = 0;
        push_window(200);
        tick();
        tick();
        checks++; if (q_at(0) !== 200) begin failures++; $display("FAIL rst_mid_first got=%0d exp=200", q_at(0)); end
        for (int k = 1; k < FRAME - 1; k++) push_window(200);
        repeat (3) tick();
        checks++; if (dcount !== 0) begin failures++; $display("FAIL rst_mid_frame_early got=%0d exp=0", dcount); end
        push_window(200);
        repeat (3) tick();
        checks++; if (dcount !== 1 || dmax !== 200 || dmin !== 200) begin
            failures++; $display("FAIL rst_mid_frame got n=%0d max=%0d min=%0d exp n=1 max=200 min=200", dcount, dmax, dmin); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        env_ready = 1'b0;
        test_reset();
        test_const();
        test_neg_fullscale();
        test_alt();
        test_backpressure();
        test_depth();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
